four_adder: RTL and testbench
=============================

# four_adder

Registered 4-bit ripple-carry adder with carry-in, carry-out and signed-overflow flag. It is used as a small arithmetic leaf in datapaths and as the reference adder for gate-level exercises. Operands are sampled with a valid strobe; the sum is registered and presented one clock later with a matching valid. The block has one clock and no other state.

## Interface
Parameters:
- WIDTH, default 4: operand and sum width. All requirements below are stated for 4; other widths follow the same rules.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk by the integrator.
- in_valid  input  1  A/B/Cin are valid this cycle.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in.
- out_valid  output  1  S/Cout/Ovf carry a new result this cycle.
- S  output  WIDTH  sum, A + B + Cin mod 2^WIDTH.
- Cout  output  1  carry out of the MSB.
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Combinational core is a ripple chain of WIDTH full_adder cells: c[0]=Cin, s[i]=A[i]^B[i]^c[i], c[i+1]=A[i]&B[i] | c[i]&(A[i]^B[i]), Cout=c[WIDTH].
- {Cout,S} equals the (WIDTH+1)-bit unsigned sum A+B+Cin exactly; no saturation.
- Ovf = c[WIDTH-1] ^ c[WIDTH]; set only when two's-complement interpretation overflows.
- When in_valid=1 on a rising edge: S, Cout, Ovf load core results; out_valid loads 1.
- When in_valid=0 on a rising edge: S, Cout, Ovf hold previous values; out_valid loads 0.
- No backpressure; a new operand set is accepted every cycle.
- X on A/B/Cin while in_valid=0 must not propagate into held outputs.

## Timing
- Reset (rst_n=0): immediately, without clock, S=0, Cout=0, Ovf=0, out_valid=0; held while rst_n=0.
- Latency: exactly 1 cycle from in_valid sample to out_valid/result.
- Throughput: 1 result per cycle; back-to-back valids produce back-to-back results in order.
- Reset asserted mid-stream: in-flight result is discarded; first result after release corresponds to first in_valid sampled after release.
- Boundary: all-ones + all-ones + 1 gives S=1111, Cout=1, Ovf=0; all-zero + Cin=0 gives S=0000, Cout=0, Ovf=0.
- Core critical path is the WIDTH-stage carry ripple; it must close within one clk period.

## Structure
- Package four_adder_pkg: constant ADDER_WIDTH=4 (default for WIDTH), typedef nibble_t = logic [ADDER_WIDTH-1:0].
- Sub-module full_adder (a, b, ci -> s, co), instantiated WIDTH times via generate to form the ripple chain.
- Top four_adder: generate chain, overflow XOR, output register bank with async active-low reset and valid-gated load.

## Test plan
- Reset: drive rst_n=0 without clock -> S=0000, Cout=0, Ovf=0, out_valid=0 immediately.
- A=0110, B=0011, Cin=1, in_valid=1 -> next cycle S=1010, Cout=0, Ovf=1, out_valid=1.
- Back-to-back: A=0100,B=1001,Cin=1 then A=0101,B=1111,Cin=1 -> S=1110,Cout=0,Ovf=0 then S=0101,Cout=1,Ovf=0 on consecutive cycles.
- A=0111, B=0001, Cin=1 -> S=1001, Cout=0, Ovf=1; then in_valid=0 with X operands -> outputs held, out_valid=0.
- Extremes: 1111+1111+1 -> S=1111,Cout=1,Ovf=0; 1000+1000+0 -> S=0000,Cout=1,Ovf=1.
- Exhaustive: all 512 (A,B,Cin) combinations streamed back-to-back -> every result matches A+B+Cin and overflow rule, 1-cycle latency; assert rst_n mid-stream -> outputs clear at once, no stale result after release.

Source files
------------

// File: rtl/four_adder_pkg.sv
// four_adder_pkg
//   Shared constants and types for the registered ripple-carry adder.
//   ADDER_WIDTH : default operand/sum width of four_adder
//   nibble_t    : operand/sum type at the default width
package four_adder_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef logic [ADDER_WIDTH-1:0] nibble_t;

endpackage : four_adder_pkg

// File: rtl/four_adder_full_adder.sv
// full_adder
//   One-bit full adder cell, the building block of the ripple chain.
//   Ports:
//     a, b : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
module full_adder
  import four_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic halfSum;

  // Propagate term is shared between the sum bit and the carry-out so the
  // cell stays in the classic generate/propagate form.
  always_comb begin
    halfSum = a ^ b;
    s       = halfSum ^ ci;
    co      = (a & b) | (ci & halfSum);
  end

endmodule : full_adder

// File: rtl/four_adder.sv
// four_adder
//   Registered WIDTH-bit ripple-carry adder with carry-in, carry-out and a
//   signed-overflow flag. Operands are captured on a valid strobe and the
//   result appears one clock later together with out_valid.
//   Ports:
//     clk       : clock, all state on rising edge
//     rst_n     : asynchronous active-low reset
//     in_valid  : A/B/Cin are valid this cycle
//     A, B      : operands (unsigned or two's complement)
//     Cin       : carry in
//     out_valid : S/Cout/Ovf carry a new result this cycle
//     S         : registered sum, A + B + Cin mod 2^WIDTH
//     Cout      : registered carry out of the MSB
//     Ovf       : registered signed overflow flag
module four_adder
  import four_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sumComb;
  logic             ovfComb;

  assign carry[0] = Cin;

  // Ripple chain: each cell consumes the carry produced by the bit below.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_chain
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sumComb[i]),
      .co (carry[i+1])
    );
  end

  // Signed overflow happens exactly when the carry into the sign bit differs
  // from the carry out of it.
  assign ovfComb = carry[WIDTH-1] ^ carry[WIDTH];

  // Output register bank. Results only load on a valid strobe, so garbage or
  // X on the operands while idle never reaches the held outputs; out_valid
  // simply mirrors the strobe one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S         <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sumComb;
        Cout <= carry[WIDTH];
        Ovf  <= ovfComb;
      end
    end
  end

endmodule : four_adder

// File: tb/tb_four_adder.sv
// tb_four_adder
//   Self-checking bench for four_adder: directed vectors with hand-computed
//   results, an exhaustive back-to-back sweep against a behavioural model,
//   and asynchronous reset behaviour (at start and mid-stream).
module tb_four_adder;
  import four_adder_pkg::*;

  logic    clk;
  logic    rst_n;
  logic    in_valid;
  nibble_t A;
  nibble_t B;
  logic    Cin;
  logic    out_valid;
  nibble_t S;
  logic    Cout;
  logic    Ovf;

  int checkCount = 0;
  int errorCount = 0;

  four_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; values are packed as {out_valid, Cout, Ovf, S}.
  task automatic checkOutput(input string tag, input logic [6:0] observed,
                             input logic [6:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got v/co/ovf/s=%b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive one operand set, let it be sampled, and return #1 after the edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic cin, input logic valid);
    A        = a;
    B        = b;
    Cin      = cin;
    in_valid = valid;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] pack(input logic v, input logic co,
                                      input logic ovf, input logic [3:0] s);
    return {v, co, ovf, s};
  endfunction

  // Independent reference: plain integer add, overflow from operand/result signs.
  function automatic logic [6:0] modelResult(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin);
    logic [4:0] sum;
    logic       ovf;
    sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    ovf = (a[3] == b[3]) && (sum[3] != a[3]);
    return {1'b1, sum[4], ovf, sum[3:0]};
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    Cin      = 1'b0;

    // Reset takes effect before any clock edge and holds across edges.
    #1;
    checkOutput("reset_immediate", pack(out_valid, Cout, Ovf, S), 7'b0);
    in_valid = 1'b1;
    A        = 4'b1111;
    B        = 4'b1111;
    Cin      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held", pack(out_valid, Cout, Ovf, S), 7'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add with signed overflow.
    applyStimulus(4'b0110, 4'b0011, 1'b1, 1'b1);
    checkOutput("add_6_3_1", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b0, 1'b1, 4'b1010));

    // Back-to-back results in consecutive cycles.
    applyStimulus(4'b0100, 4'b1001, 1'b1, 1'b1);
    checkOutput("b2b_first", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b0, 1'b0, 4'b1110));
    applyStimulus(4'b0101, 4'b1111, 1'b1, 1'b1);
    checkOutput("b2b_second", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b1, 1'b0, 4'b0101));

    // Overflow, then idle with X operands: results hold, out_valid drops.
    applyStimulus(4'b0111, 4'b0001, 1'b1, 1'b1);
    checkOutput("add_7_1_1", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b0, 1'b1, 4'b1001));
    applyStimulus(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
    checkOutput("hold_x_idle", pack(out_valid, Cout, Ovf, S), pack(1'b0, 1'b0, 1'b1, 4'b1001));
    applyStimulus(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
    checkOutput("hold_x_idle2", pack(out_valid, Cout, Ovf, S), pack(1'b0, 1'b0, 1'b1, 4'b1001));

    // Extremes.
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1);
    checkOutput("all_ones", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b1, 1'b0, 4'b1111));
    applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b1);
    checkOutput("min_neg", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b1, 1'b1, 4'b0000));
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("all_zero", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b0, 1'b0, 4'b0000));

    // Exhaustive sweep streamed back-to-back.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] vec;
      vec = i[8:0];
      applyStimulus(vec[8:5], vec[4:1], vec[0], 1'b1);
      checkOutput($sformatf("sweep_%0d", i), pack(out_valid, Cout, Ovf, S),
                  modelResult(vec[8:5], vec[4:1], vec[0]));
    end

    // Mid-stream reset: clears at once, no stale result after release.
    applyStimulus(4'b0101, 4'b0110, 1'b0, 1'b1);
    checkOutput("pre_reset", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b0, 1'b1, 4'b1011));
    A        = 4'b0011;
    B        = 4'b0100;
    Cin      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_clear", pack(out_valid, Cout, Ovf, S), 7'b0);
    @(posedge clk);
    #1;
    checkOutput("midreset_held", pack(out_valid, Cout, Ovf, S), 7'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1010, 4'b0101, 1'b0, 1'b0);
    checkOutput("post_reset_idle", pack(out_valid, Cout, Ovf, S), 7'b0);
    applyStimulus(4'b0010, 4'b0011, 1'b0, 1'b1);
    checkOutput("post_reset_first", pack(out_valid, Cout, Ovf, S), pack(1'b1, 1'b0, 1'b0, 4'b0101));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule : tb_four_adder
